// File: rtl/circuit_pkg.sv
// circuit_pkg: shared definitions for the logic-circuit library cells.
//   MAJ3_TT    : truth table of majority-of-three, bit i = f({a,b,c} = i).
//   idx3_t     : 3-bit input index {a,b,c}, a is the MSB.
//   idx_onehot : one-hot 8-bit mask selecting the bit for a given index.
package circuit_pkg;

  localparam logic [7:0] MAJ3_TT = 8'hE8;

  typedef logic [2:0] idx3_t;

  function automatic logic [7:0] idx_onehot(input idx3_t i_idx);
    return 8'h01 << i_idx;
  endfunction

endpackage

// File: rtl/circuit_08_lut3.sv
// lut3: 3-input look-up table (8-entry mux), reusable by other library cells.
// Ports:
//   i_idx : input index {a,b,c}
//   o_y   : TT[i_idx], purely combinational
module lut3
  import circuit_pkg::*;
#(
  parameter logic [7:0] TT = MAJ3_TT
) (
  input  idx3_t i_idx,
  output logic  o_y
);

  // An unknown index propagates as X through the variable part-select.
  assign o_y = TT[i_idx];

endmodule

// File: rtl/circuit_08.sv
// circuit_08: three-input Boolean function cell (majority-of-three by default).
// No handshake: d is a pure function of the inputs; d_q and seen simply
// capture the inputs on every rising clk edge that is not a reset edge.
// Ports:
//   clk      : system clock, rising edge active
//   rst      : synchronous reset, active-high
//   a, b, c  : function inputs, index = {a,b,c} (a is the MSB)
//   d        : combinational result TRUTH_TABLE[{a,b,c}], unaffected by reset
//   d_q      : d registered on rising clk, cleared by reset
//   seen     : sticky mask, bit i set once index i is sampled on an edge
//   all_seen : high when every index has been sampled (seen == 8'hFF)
module circuit_08
  import circuit_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE = MAJ3_TT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       d,
  output logic       d_q,
  output logic [7:0] seen,
  output logic       all_seen
);

  idx3_t      w_idx;
  logic       w_d;
  logic       r_d_q;
  logic [7:0] r_seen;

  assign w_idx = {a, b, c};

  lut3 #(
    .TT(TRUTH_TABLE)
  ) u_lut3 (
    .i_idx(w_idx),
    .o_y  (w_d)
  );

  // Reset wins over a simultaneous input change: the index sampled on a
  // reset edge is deliberately not recorded in seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_q  <= 1'b0;
      r_seen <= 8'h00;
    end else begin
      r_d_q <= w_d;
      // An unknown index must not mark any coverage bit.
      if (!$isunknown(w_idx)) begin
        r_seen <= r_seen | idx_onehot(w_idx);
      end
    end
  end

  assign d        = w_d;
  assign d_q      = r_d_q;
  assign seen     = r_seen;
  assign all_seen = &r_seen;

endmodule

// File: tb/tb_circuit_08.sv
// Bench for circuit_08: a majority instance (default table) and an XOR3
// instance (TRUTH_TABLE = 8'h96) share the same inputs. The driver pushes
// the expected post-edge state for each clock edge into exp_q; a monitor
// pops and compares on every rising edge.
module tb_circuit_08;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       c = 1'b0;

  logic       d_maj, dq_maj, all_maj;
  logic [7:0] seen_maj;
  logic       d_xor, dq_xor, all_xor;
  logic [7:0] seen_xor;

  int total = 0;
  int bad   = 0;

  // {expected d_q majority, expected d_q xor, expected seen}
  logic [9:0] exp_q[$];

  // Reference coverage set: which indices have been sampled since reset.
  bit m_seen[8];

  // ---------------- clock / reset ----------------
  always #5 if (clk_en) clk = ~clk;

  // ---------------- DUTs ----------------
  circuit_08 u_maj (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d_maj),
    .d_q     (dq_maj),
    .seen    (seen_maj),
    .all_seen(all_maj)
  );

  circuit_08 #(
    .TRUTH_TABLE(8'h96)
  ) u_xor (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d_xor),
    .d_q     (dq_xor),
    .seen    (seen_xor),
    .all_seen(all_xor)
  );

  // ---------------- reference model ----------------
  function automatic int ones_of(input int idx);
    return ((idx >> 2) & 1) + ((idx >> 1) & 1) + (idx & 1);
  endfunction

  function automatic logic maj_ref(input int idx);
    return (ones_of(idx) >= 2);
  endfunction

  function automatic logic xor_ref(input int idx);
    return (ones_of(idx) % 2) == 1;
  endfunction

  function automatic logic [7:0] seen_ref();
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) if (m_seen[i]) v = v + (8'd1 << i);
    return v;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_idx(input int idx);
    a = idx[2];
    b = idx[1];
    c = idx[0];
  endtask

  // Combinational check with the clock stopped.
  task automatic comb_step(input int idx);
    drive_idx(idx);
    #1;
    check_bit("d_maj_comb", d_maj, maj_ref(idx));
    check_bit("d_xor_comb", d_xor, xor_ref(idx));
    #9;
  endtask

  // One clock edge: set inputs while clk is low, record the expected
  // post-edge state, check d immediately, then wait for the edge to pass.
  task automatic step(input int idx, input bit r);
    logic [7:0] s;
    logic       em, ex;
    drive_idx(idx);
    rst = r;
    if (r) begin
      for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
      em = 1'b0;
      ex = 1'b0;
    end else begin
      m_seen[idx] = 1'b1;
      em = maj_ref(idx);
      ex = xor_ref(idx);
    end
    s = seen_ref();
    exp_q.push_back({em, ex, s});
    #1;
    check_bit("d_maj", d_maj, maj_ref(idx));
    check_bit("d_xor", d_xor, xor_ref(idx));
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [9:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_bit("dq_maj", dq_maj, e[9]);
      check_bit("dq_xor", dq_xor, e[8]);
      check_byte("seen_maj", seen_maj, e[7:0]);
      check_byte("seen_xor", seen_xor, e[7:0]);
      check_bit("all_maj", all_maj, &e[7:0]);
      check_bit("all_xor", all_xor, &e[7:0]);
    end else begin
      total++;
      bad++;
      $display("FAIL unexpected_edge: got edge expected none at %0t", $time);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    // Exhaustive combinational sweep, no clock, rst low.
    for (int i = 0; i < 8; i++) comb_step(i);

    // Start the clock; clk is low here.
    clk_en = 1'b1;

    // Reset edge with inputs at 111: d stays 1 while registers clear.
    step(7, 1'b1);

    // Coverage sweep through every index, then repeats.
    for (int i = 0; i < 8; i++) step(i, 1'b0);
    step(5, 1'b0);
    step(0, 1'b0);

    // Registered path: 011 then 100.
    step(3, 1'b0);
    step(4, 1'b0);

    // Reset mid-sweep, then resume at 100.
    step(0, 1'b1);
    for (int i = 0; i < 4; i++) step(i, 1'b0);
    step(6, 1'b1);
    step(4, 1'b0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      step(int'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
    end

    // Stop the clock while low and confirm nothing is left unchecked.
    clk_en = 1'b0;
    #20;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/circuit_08.md
Name: circuit_08

Overview:
- Three-input single-output Boolean function block. Implements majority-of-three by default, selectable via a truth-table parameter.
- Output d is purely combinational from a, b, c and is valid with no clock activity.
- A registered copy of d and an input-coverage mask are provided on a single clock for downstream synchronous logic and bench coverage.
- Leaf cell in the course logic-circuit library.

Parameters:
- TRUTH_TABLE, 8'hE8, bit i is the value of d for input index i = {a,b,c} (a is the MSB); default is majority-of-three.

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  synchronous reset, active-high
- a  input  1  function input, MSB of index
- b  input  1  function input, middle bit of index
- c  input  1  function input, LSB of index
- d  output  1  combinational result, TRUTH_TABLE[{a,b,c}]
- d_q  output  1  d registered on rising clk
- seen  output  8  sticky mask; bit i set once index i has been sampled on a clock edge
- all_seen  output  1  high when seen == 8'hFF

Behaviour:
- d:
  - Combinational: d = TRUTH_TABLE[{a,b,c}].
  - Zero cycles latency; independent of clk and rst.
  - Must settle within the same delta/timestep as an input change.
- With the default parameter, d is 1 exactly for {a,b,c} = 011, 101, 110, 111; otherwise 0.
- d_q:
  - On each rising clk: if rst then d_q <= 0, else d_q <= d.
  - One-cycle latency.
- seen:
  - On each rising clk: if rst then seen <= 8'h00, else seen <= seen | (8'h01 << {a,b,c}).
  - Bits never clear except by reset.
- all_seen: combinational reduction-AND of seen.
- Reset values: d_q = 0, seen = 8'h00, all_seen = 0. d is not affected by reset.
- Reset mid-operation: registered state clears on the edge where rst is high. d continues to track the inputs.
- Simultaneous rst and input change at a clock edge: rst wins, and the sampled index is not recorded.
- X or Z on any input: d is X. seen must not set any bit for an unknown index (guard with a known-value check in simulation).
- No handshake and no state machine.

Decomposition:
- Shared package circuit_pkg:
  - localparam MAJ3_TT = 8'hE8.
  - typedef logic [2:0] idx3_t for the {a,b,c} index.
- No sub-module needed. Optional leaf lut3 (8-entry mux) may be split out if the library reuses it for other circuitNN cells.

Test Plan:
- Exhaustive combinational sweep, no clock running, rst held at 0: apply {a,b,c} = 000..111 in 10 ns steps -> d = 0,0,0,1,0,1,1,1.
- Registered path: clocked, rst deasserted, apply 011 then 100 on consecutive cycles -> d_q = 1 one cycle after 011, then 0 one cycle after 100.
- Reset: assert rst for one edge with inputs at 111 -> d_q = 0, seen = 8'h00, all_seen = 0, while d stays 1.
- Coverage: clock through all 8 indices once after reset -> seen reaches 8'hFF and all_seen goes high on the edge sampling the last index. Repeating indices leaves seen unchanged.
- Reset mid-sweep: after indices 000..011 (seen = 8'h0F), assert rst -> seen = 8'h00. Resuming at 100 gives seen = 8'h10.
- Parameter override TRUTH_TABLE = 8'h96 (XOR3): full sweep -> d = 0,1,1,0,1,0,0,1.
